// File: rtl/adsr_env_pkg.sv
// Shared definitions for the ADSR envelope generator: state encoding and
// full-scale helper.
package adsr_env_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_t;

  // Full-scale envelope value for a given bit width (2^width - 1).
  function automatic logic [31:0] env_max(input int unsigned width);
    logic [63:0] one;
    one = 64'd1;
    return 32'((one << width) - 64'd1);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus rising-edge detector producing a one-cycle pulse.
// Resets to all-ones so a level that is already high never fires a pulse.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q;
  logic sync1_d, sync2_d, prev_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/adsr_env.sv
// ADSR amplitude envelope stepped by the divided clk_adsr rate clock.
// Gate edges take priority over level steps in the same cycle.
module adsr_env
  import adsr_env_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_adsr,
  input  logic             gate,
  input  logic [WIDTH-1:0] attack_step,
  input  logic [WIDTH-1:0] decay_step,
  input  logic [WIDTH-1:0] sustain_lvl,
  input  logic [WIDTH-1:0] release_step,
  output logic [WIDTH-1:0] env,
  output logic [2:0]       state,
  output logic             active
);

  localparam logic [WIDTH-1:0] ENV_MAX = WIDTH'(env_max(WIDTH));

  logic tick;
  logic gate_q;
  logic rise, fall;

  adsr_state_t      state_q, state_d;
  logic [WIDTH-1:0] env_q, env_d;
  logic [WIDTH:0]   sum, diff;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (clk_adsr),
    .pulse (tick)
  );

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    sum     = {1'b0, env_q} + {1'b0, attack_step};
    diff    = '0;
    if (rise) begin
      state_d = ATTACK;
    end else if (fall && (state_q == ATTACK || state_q == DECAY ||
                          state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (tick) begin
      unique case (state_q)
        IDLE: env_d = '0;
        ATTACK: begin
          if (sum >= {1'b0, ENV_MAX}) begin
            env_d   = ENV_MAX;
            state_d = DECAY;
          end else begin
            env_d = sum[WIDTH-1:0];
          end
        end
        DECAY: begin
          // Borrow or undershoot both clamp to sustain, which also covers
          // sustain_lvl being raised above env mid-decay.
          diff = {1'b0, env_q} - {1'b0, decay_step};
          if (diff[WIDTH] || diff[WIDTH-1:0] <= sustain_lvl) begin
            env_d   = sustain_lvl;
            state_d = SUSTAIN;
          end else begin
            env_d = diff[WIDTH-1:0];
          end
        end
        SUSTAIN: env_d = sustain_lvl;
        RELEASE: begin
          diff = {1'b0, env_q} - {1'b0, release_step};
          if (diff[WIDTH] || diff[WIDTH-1:0] == '0) begin
            env_d   = '0;
            state_d = IDLE;
          end else begin
            env_d = diff[WIDTH-1:0];
          end
        end
        default: begin
          env_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    // Unreachable codes recover regardless of tick or gate activity.
    if (!(state_q inside {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE})) begin
      env_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      env_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      gate_q  <= gate;
    end
  end

  assign env    = env_q;
  assign state  = state_q;
  assign active = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// Directed plus randomized bench for adsr_env against a behavioural envelope
// model driven by the history of sampled clk_adsr values.
module tb_adsr_env;

  localparam int W   = 8;
  localparam int MAX = 255;

  logic         clk = 1'b0;
  logic         rst, clk_adsr, gate;
  logic [W-1:0] attack_step, decay_step, sustain_lvl, release_step;
  logic [W-1:0] env;
  logic [2:0]   state;
  logic         active;

  adsr_env #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_adsr     (clk_adsr),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_lvl  (sustain_lvl),
    .release_step (release_step),
    .env          (env),
    .state        (state),
    .active       (active)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: envelope level, state code, last gate, clk_adsr samples at the
  // previous three edges (hist[0] most recent).
  int m_env, m_st, m_gq;
  int hist[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Called at a negedge with inputs stable; advances one clk edge.
  task automatic cyc();
    int t, rs, fl, d;
    t = (hist[1] == 1 && hist[2] == 0) ? 1 : 0;
    chk("tick", {31'd0, dut.tick}, t);
    if (rst) begin
      m_env = 0; m_st = 0; m_gq = 0;
      hist[0] = 1; hist[1] = 1; hist[2] = 1;
    end else begin
      rs = (gate && !m_gq) ? 1 : 0;
      fl = (!gate && m_gq) ? 1 : 0;
      if (rs) m_st = 1;
      else if (fl && m_st >= 1 && m_st <= 3) m_st = 4;
      else if (t) begin
        case (m_st)
          0: m_env = 0;
          1: begin
            m_env = m_env + int'(attack_step);
            if (m_env >= MAX) begin m_env = MAX; m_st = 2; end
          end
          2: begin
            d = m_env - int'(decay_step);
            if (d <= int'(sustain_lvl)) begin m_env = int'(sustain_lvl); m_st = 3; end
            else m_env = d;
          end
          3: m_env = int'(sustain_lvl);
          default: begin
            d = m_env - int'(release_step);
            if (d <= 0) begin m_env = 0; m_st = 0; end
            else m_env = d;
          end
        endcase
      end
      m_gq = gate ? 1 : 0;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = clk_adsr ? 1 : 0;
    end
    @(posedge clk);
    #1;
    chk("env", {24'd0, env}, m_env);
    chk("state", {29'd0, state}, m_st);
    chk("active", {31'd0, active}, (m_st != 0) ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    clk_adsr = 1'b1;
    repeat (hi) cyc();
    clk_adsr = 1'b0;
    repeat (lo) cyc();
  endtask

  int hold_env;

  initial begin
    m_env = 0; m_st = 0; m_gq = 0;
    hist[0] = 1; hist[1] = 1; hist[2] = 1;
    rst = 1'b1; clk_adsr = 1'b1; gate = 1'b0;
    attack_step = 8'd64; decay_step = 8'd16; sustain_lvl = 8'd128; release_step = 8'd32;
    @(negedge clk);
    repeat (3) cyc();
    rst = 1'b0;
    repeat (6) cyc();
    chk("reset_env", {24'd0, env}, 0);
    chk("reset_state", {29'd0, state}, 0);

    // Long high level yields a single tick.
    clk_adsr = 1'b0;
    repeat (3) cyc();
    pulse(32, 4);

    // Full envelope cycle.
    gate = 1'b1;
    cyc();
    chk("gate_attack", {29'd0, state}, 1);
    repeat (4) pulse(3, 3);
    chk("attack_peak", {24'd0, env}, 255);
    chk("to_decay", {29'd0, state}, 2);
    repeat (8) pulse(3, 3);
    chk("sustain_env", {24'd0, env}, 128);
    chk("to_sustain", {29'd0, state}, 3);
    repeat (2) pulse(3, 3);
    gate = 1'b0;
    cyc();
    chk("to_release", {29'd0, state}, 4);
    repeat (4) pulse(3, 3);
    chk("release_idle", {29'd0, state}, 0);
    chk("release_inactive", {31'd0, active}, 0);

    // Retrigger from RELEASE at env=100.
    attack_step = 8'd100;
    gate = 1'b1; cyc();
    pulse(3, 3);
    gate = 1'b0; cyc();
    gate = 1'b1; cyc();
    chk("retrig_state", {29'd0, state}, 1);
    chk("retrig_env", {24'd0, env}, 100);
    attack_step = 8'd200;
    pulse(3, 3);
    chk("retrig_sat", {24'd0, env}, 255);

    // Back to IDLE, then a gate rise coincident with a tick.
    release_step = 8'd255;
    gate = 1'b0; cyc();
    pulse(3, 3);
    chk("fast_release", {29'd0, state}, 0);
    attack_step = 8'd37;
    clk_adsr = 1'b1; cyc(); cyc();
    gate = 1'b1; cyc();
    chk("coinc_state", {29'd0, state}, 1);
    chk("coinc_env", {24'd0, env}, 0);
    clk_adsr = 1'b0; repeat (3) cyc();
    pulse(3, 3);
    chk("coinc_next", {24'd0, env}, 37);

    // Sustain raised above env mid-decay.
    attack_step = 8'd255; decay_step = 8'd75; sustain_lvl = 8'd50;
    pulse(3, 3);
    pulse(3, 3);
    chk("decay_180", {24'd0, env}, 180);
    sustain_lvl = 8'd200;
    pulse(3, 3);
    chk("sus_raise_env", {24'd0, env}, 200);
    chk("sus_raise_state", {29'd0, state}, 3);

    // Zero attack step stalls in ATTACK.
    gate = 1'b0; cyc();
    attack_step = 8'd0;
    gate = 1'b1; cyc();
    hold_env = int'(env);
    repeat (10) pulse(3, 3);
    chk("stall_env", {24'd0, env}, hold_env);
    chk("stall_state", {29'd0, state}, 1);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(4) == 0) clk_adsr = ~clk_adsr;
      if ($urandom_range(39) == 0) gate = ~gate;
      if ($urandom_range(29) == 0) begin
        case ($urandom_range(3))
          0: attack_step = 8'd0;
          1: attack_step = 8'd255;
          default: attack_step = 8'($urandom);
        endcase
        decay_step   = 8'($urandom_range(60));
        release_step = ($urandom_range(5) == 0) ? 8'd0 : 8'($urandom_range(80));
      end
      if ($urandom_range(49) == 0)
        sustain_lvl = ($urandom_range(4) == 0) ? 8'd255 : 8'($urandom);
      rst = ($urandom_range(599) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adsr_env.md
Name: adsr_env

Overview:
- Envelope generator directly downstream of the clock divider; consumes the slow `clk_adsr` output as its rate base.
- Produces an amplitude envelope for the voice: attack, decay, sustain, release.
- Runs entirely on the system clock `clk`.
- `clk_adsr` is treated as an asynchronous level: synchronised, then edge-detected into a one-cycle step strobe.

Parameters:
- WIDTH, 8, envelope/sustain/step bit width; full scale is 2^WIDTH-1.

Ports:
- clk  in  1  system clock (same clock that feeds the divider)
- rst  in  1  synchronous reset, active-high
- clk_adsr  in  1  divided ADSR rate clock from divider, asynchronous level
- gate  in  1  note on/off, synchronous to clk
- attack_step  in  WIDTH  increment per step in ATTACK
- decay_step  in  WIDTH  decrement per step in DECAY
- sustain_lvl  in  WIDTH  sustain target level
- release_step  in  WIDTH  decrement per step in RELEASE
- env  out  WIDTH  current envelope level
- state  out  3  current state encoding
- active  out  1  high when state != IDLE

Behaviour:
- Reset (rst high at a clk edge) forces:
  - env=0, state=IDLE, active=0.
  - Synchroniser flops sync1, sync2 and prev all =1, so no spurious step if clk_adsr is high at reset release.
  - gate_q=0.
- Step strobe:
  - sync1<=clk_adsr, sync2<=sync1, prev<=sync2.
  - tick = sync2 & ~prev, combinational.
  - One clk cycle wide per clk_adsr rising edge.
  - Asserted in the 3rd clk cycle after clk_adsr is first sampled high.
- Gate edge detection:
  - gate_q<=gate.
  - rise = gate & ~gate_q; fall = ~gate & gate_q.
- Gate events, in any cycle, independent of tick:
  - rise in any state -> ATTACK. env not reset (retrigger continues from current level).
  - fall in ATTACK, DECAY or SUSTAIN -> RELEASE.
  - fall in IDLE or RELEASE: ignored.
- Priority: a gate event and a tick in the same cycle:
  - The gate transition wins.
  - env is unchanged that cycle and the tick is dropped.
- Level updates happen only on tick cycles with no gate event. All arithmetic is saturating, using WIDTH+1-bit intermediates.
  - ATTACK: env<=min(env+attack_step, MAX). If the result equals MAX, state<=DECAY on the same edge.
  - DECAY: env<=max(env-decay_step, sustain_lvl), evaluated signed/with borrow. If the result equals sustain_lvl, state<=SUSTAIN on the same edge. If sustain_lvl > env (sustain changed mid-decay), env<=sustain_lvl and state<=SUSTAIN.
  - SUSTAIN: env<=sustain_lvl on every tick (tracks live changes).
  - RELEASE: env<=max(env-release_step, 0). If the result equals 0, state<=IDLE.
  - IDLE: env held at 0.
- Zero step value: env holds and the state stalls indefinitely. This is legal; there is no timeout.
- sustain_lvl=MAX: the first DECAY tick moves directly to SUSTAIN with env=MAX.
- Step inputs are sampled on the tick edge only; changes between ticks have no effect.
- Outputs are registered except active, which is decoded from the state register.
- rst asserted mid-envelope: next edge returns to IDLE, env=0. The synchroniser restarts at all-ones.
- State encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Codes 5-7 are unreachable and recover to IDLE with env=0.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE..RELEASE).
  - ENV_MAX derived from WIDTH.
- One sub-module, edge_sync, is natural:
  - 2-flop synchroniser plus rising-edge detector.
  - Synchronous reset to all-ones.
  - Outputs a single-cycle pulse.
  - Reusable for clk_sample in the sample path.

Test Plan:
- Reset with clk_adsr held high, then release: no tick. env=0, state=0, active=0 until clk_adsr goes low then high.
- clk_adsr rising edge after reset: tick high for exactly 1 cycle, 3 cycles after the edge is sampled. A 32-cycle-high level gives only one tick.
- Full cycle, WIDTH=8, attack=64, decay=16, sustain=128, release=32:
  - gate=1 -> state ATTACK.
  - Ticks give env 64, 128, 192, 255; state DECAY after the 4th tick.
  - Ticks give env 239..., reaching 128 after 8 decay ticks -> SUSTAIN.
  - gate=0 -> RELEASE; 4 ticks to 0 -> IDLE, active=0.
- Retrigger at env=100 in RELEASE (gate low->high): state ATTACK with env stays 100. With attack=200, the next tick gives env=255 (saturates) and state DECAY.
- Gate rise coincident with tick in IDLE: state ATTACK, env stays 0 that cycle. The next tick gives env=attack_step.
- Raise sustain_lvl from 50 to 200 while in DECAY at env=180: next tick gives env=200, state SUSTAIN. attack_step=0 in ATTACK: env constant over 10 ticks and state stays ATTACK.
